// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous memory (1-cycle read
//                latency) between an instruction-fetch requester and a
//                data load/store requester. At most one memory command is
//                issued per cycle and every granted access produces a
//                single-cycle valid pulse on the owner's side.
//                Default policy: data priority with a fetch starvation guard.
//                Optional: define MEM_ARB_RR_EN for round-robin arbitration
//                (the starvation counter is then not built).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch requester
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_rdata,
    // data load/store requester
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_valid,
    output logic [DATA_W-1:0] o_d_rdata,
    // memory macro side
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [IDX_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic              w_if_win;     // fetch wins arbitration (ungated)
    logic              w_d_win;      // data wins arbitration (ungated)
    logic              w_if_gnt;     // fetch grant, forced low in reset
    logic              w_d_gnt;      // data grant, forced low in reset

    logic [1:0]        pend_d;       // owner of the in-flight access {if, d}
    logic [1:0]        pend_q;
    logic              d_rd_d;       // in-flight data access is a read
    logic              d_rd_q;
    logic [DATA_W-1:0] if_rdata_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_d;
    logic [DATA_W-1:0] d_rdata_q;

    // Address bits outside the word index are intentionally ignored.
    logic              w_unused;
    assign w_unused = ^{i_if_addr[ADDR_W-1:IDX_W+2], i_if_addr[1:0],
                        i_d_addr[ADDR_W-1:IDX_W+2], i_d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
    // ------------------------------------------------------------------
    // Round-robin policy: last_if_q = 1 when fetch held the latest grant.
    // Resets to "data" so fetch takes the first conflict.
    // ------------------------------------------------------------------
    logic last_if_d;
    logic last_if_q;

    // Conflict goes to whichever requester did not win last time.
    always_comb begin
        w_if_win = 1'b0;
        w_d_win  = 1'b0;
        if (i_if_req && i_d_req) begin
            w_if_win = ~last_if_q;
            w_d_win  = last_if_q;
        end else begin
            w_if_win = i_if_req;
            w_d_win  = i_d_req;
        end
    end

    // Remember the owner of every grant; hold when idle.
    always_comb begin
        last_if_d = last_if_q;
        if (w_if_gnt) begin
            last_if_d = 1'b1;
        end else if (w_d_gnt) begin
            last_if_d = 1'b0;
        end
    end

    // Last-grant flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_if_q <= 1'b0;
        end else begin
            last_if_q <= last_if_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Data-priority policy with a saturating starvation counter that
    // forces a fetch grant after STARVE_MAX consecutive denied cycles.
    // ------------------------------------------------------------------
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_d;
    logic [3:0] starve_q;
    logic       w_force_if;

    // Data wins unless fetch has been starved long enough.
    always_comb begin
        w_force_if = (starve_q == C_STARVE_MAX) && i_if_req;
        w_d_win    = i_d_req && !w_force_if;
        w_if_win   = i_if_req && !w_d_win;
    end

    // Count denied fetch cycles, saturate at the limit, clear otherwise.
    always_comb begin
        starve_d = 4'd0;
        if (i_if_req && !w_if_gnt) begin
            if (starve_q >= C_STARVE_MAX) begin
                starve_d = C_STARVE_MAX;
            end else begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Grants are combinational; reset holds them (and the memory command)
    // low so nothing reaches the macro while rst_n is asserted.
    // ------------------------------------------------------------------
    assign w_if_gnt = w_if_win & rst_n;
    assign w_d_gnt  = w_d_win  & rst_n;
    assign o_if_gnt = w_if_gnt;
    assign o_d_gnt  = w_d_gnt;

    // Memory command mux: route the winner's index and write data.
    always_comb begin
        o_mem_en    = w_if_gnt | w_d_gnt;
        o_mem_we    = w_d_gnt & i_d_we;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_d_gnt) begin
            o_mem_addr  = i_d_addr[IDX_W+1:2];
            o_mem_wdata = i_d_wdata;
        end else if (w_if_gnt) begin
            o_mem_addr  = i_if_addr[IDX_W+1:2];
        end
    end

    // ------------------------------------------------------------------
    // Response path. The memory returns data in the cycle after the
    // command, which is the same cycle the owner's valid is high. The
    // read data is forwarded straight through during that cycle and
    // captured at its closing edge so it stays stable until the next
    // completion for the same owner.
    // ------------------------------------------------------------------
    // Next-state for the owner tracking and the held read data.
    always_comb begin
        pend_d     = {w_if_gnt, w_d_gnt};
        d_rd_d     = w_d_gnt & ~i_d_we;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (pend_q[1]) begin
            if_rdata_d = i_mem_rdata;
        end
        if (pend_q[0] && d_rd_q) begin
            d_rdata_d = i_mem_rdata;
        end
    end

    // Owner register and held read data; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 2'b00;
            d_rd_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            d_rd_q     <= d_rd_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Completion pulses and visible read data.
    always_comb begin
        o_if_valid = pend_q[1];
        o_d_valid  = pend_q[0];
        o_if_rdata = if_rdata_d;
        o_d_rdata  = d_rdata_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. A stimulus process drives
//                requests, predicts grants from the arbitration rules and
//                pushes expected responses; a monitor pops and compares on
//                every valid. Honours MEM_ARB_RR_EN for the policy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int IDX_W      = 8;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 256;
`ifdef MEM_ARB_RR_EN
    localparam logic [9:0] EXP_PAT = 10'b0101010101;
`else
    localparam logic [9:0] EXP_PAT = 10'b1000010000;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_if_req = 1'b0;
    logic [ADDR_W-1:0] i_if_addr = '0;
    logic              o_if_gnt;
    logic              o_if_valid;
    logic [DATA_W-1:0] o_if_rdata;
    logic              i_d_req = 1'b0;
    logic              i_d_we = 1'b0;
    logic [ADDR_W-1:0] i_d_addr = '0;
    logic [DATA_W-1:0] i_d_wdata = '0;
    logic              o_d_gnt;
    logic              o_d_valid;
    logic [DATA_W-1:0] o_d_rdata;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [IDX_W-1:0]  o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_gnt   (o_if_gnt),
        .o_if_valid (o_if_valid),
        .o_if_rdata (o_if_rdata),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_gnt    (o_d_gnt),
        .o_d_valid  (o_d_valid),
        .o_d_rdata  (o_d_rdata),
        .o_mem_en   (o_mem_en),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: synchronous write, 1-cycle read latency.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) ram[o_mem_addr] = o_mem_wdata;
            else          mem_rdata <= ram[o_mem_addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        bit          wr;
        logic [31:0] data;
    } resp_t;

    resp_t       if_q[$];
    resp_t       d_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          starve = 0;
    bit          last_if = 1'b0;
    logic [31:0] if_hold = '0;
    logic [31:0] d_hold = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares valid pulses and held read data against the scoreboard.
    always @(negedge clk) begin
        resp_t e;
        bit    due;
        due = (if_q.size() > 0) && (if_q[0].due == cyc);
        chk("if_valid", 64'(o_if_valid), 64'(due));
        if (due) begin
            e = if_q.pop_front();
            if_hold = e.data;
        end
        chk("if_rdata", 64'(o_if_rdata), 64'(if_hold));
        due = (d_q.size() > 0) && (d_q[0].due == cyc);
        chk("d_valid", 64'(o_d_valid), 64'(due));
        if (due) begin
            e = d_q.pop_front();
            if (!e.wr) d_hold = e.data;
        end
        chk("d_rdata", 64'(o_d_rdata), 64'(d_hold));
    end

    // One cycle of stimulus: drive, predict grant from the policy rules,
    // check the memory command and queue the expected response.
    task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] dwd,
                        output bit gi, output bit gd);
        int unsigned ii;
        int unsigned di;
        @(posedge clk);
        #1;
        i_if_req  = ir;
        i_if_addr = ia;
        i_d_req   = dr;
        i_d_we    = dw;
        i_d_addr  = da;
        i_d_wdata = dwd;
        #1;
`ifdef MEM_ARB_RR_EN
        gi = ir && (!dr || !last_if);
`else
        gi = ir && (!dr || (starve == STARVE_MAX));
`endif
        gd = dr && !gi;
        chk("grant", 64'({o_if_gnt, o_d_gnt}), 64'({gi, gd}));
        ii = (ia / 4) % DEPTH;
        di = (da / 4) % DEPTH;
        if (gi) begin
            chk("if_mem_cmd", 64'({o_mem_en, o_mem_we, o_mem_addr}), 64'({1'b1, 1'b0, 8'(ii)}));
            if_q.push_back('{cyc + 1, 1'b0, ref_mem[ii]});
        end else if (gd) begin
            chk("d_mem_cmd", 64'({o_mem_en, o_mem_we, o_mem_addr}), 64'({1'b1, dw, 8'(di)}));
            if (dw) begin
                chk("d_mem_wdata", 64'(o_mem_wdata), 64'(dwd));
                ref_mem[di] = dwd;
                d_q.push_back('{cyc + 1, 1'b1, 32'h0});
            end else begin
                d_q.push_back('{cyc + 1, 1'b0, ref_mem[di]});
            end
        end else begin
            chk("mem_idle", 64'(o_mem_en), 64'(0));
        end
        if (gi) last_if = 1'b1;
        else if (gd) last_if = 1'b0;
        if (ir && !gi) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        else starve = 0;
    endtask

    task automatic idle(input int n);
        bit gi;
        bit gd;
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    endtask

    // Reset with both requests raised: nothing may be granted or completed.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_q.delete();
        d_q.delete();
        if_hold = '0;
        d_hold  = '0;
        starve  = 0;
        last_if = 1'b0;
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        i_d_we   = 1'b1;
        #1;
        chk("rst_cmd", 64'({o_if_gnt, o_d_gnt, o_mem_en, o_mem_we}), 64'(0));
        chk("rst_valid", 64'({o_if_valid, o_d_valid}), 64'(0));
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        i_d_we   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Both requesters held high for ten cycles; record who the DUT grants.
    task automatic conflict_seq();
        logic [9:0] pat;
        bit gi;
        bit gd;
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, $urandom, 32'h0, gi, gd);
            pat[k] = o_if_gnt;
        end
        chk("conflict_pattern", 64'(pat), 64'(EXP_PAT));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gi;
        bit          gd;
        bit          ip;
        bit          dp;
        bit          dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] v;
        for (int k = 0; k < DEPTH; k++) begin
            v = $urandom;
            ram[k] = v;
            ref_mem[k] = v;
        end
        ram[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        ram[0] = 32'hCAFEF00D;
        ref_mem[0] = 32'hCAFEF00D;

        do_reset();
        conflict_seq();
        idle(2);

        // fetch only from 0x10 -> word 4
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        idle(3);
        chk("fetch_hold", 64'(o_if_rdata), 64'(32'hDEADBEEF));

        // store then load back-to-back at 0x24
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'h12345678, gi, gd);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, gi, gd);
        idle(2);
        chk("load_back", 64'(o_d_rdata), 64'(32'h12345678));

        // index wrap: 0x400 -> word 0, 0xFFFFFFFF -> word 255
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, gi, gd);
        step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        idle(2);
        chk("wrap_data", 64'(o_d_rdata), 64'(32'hCAFEF00D));

        // reset the cycle after a fetch read grant
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        do_reset();
        chk("rst_rdata", 64'({o_if_rdata, o_d_rdata}), 64'(0));
        conflict_seq();
        idle(2);

        // randomized traffic with held requests, withdrawals and address changes
        ip = 1'b0;
        dp = 1'b0;
        dw = 1'b0;
        ia = '0;
        da = '0;
        dwd = '0;
        for (int k = 0; k < 600; k++) begin
            if (!ip) begin
                if ($urandom_range(0, 3) != 0) begin
                    ip = 1'b1;
                    ia = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ip = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                ia = $urandom;
            end
            if (!dp) begin
                if ($urandom_range(0, 2) != 0) begin
                    dp  = 1'b1;
                    dw  = 1'($urandom_range(0, 1));
                    da  = $urandom;
                    dwd = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                dp = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                da = $urandom;
            end
            step(ip, ia, dp, dw, da, dwd, gi, gd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
        end
        idle(3);
        chk("drain_if", 64'(if_q.size()), 64'(0));
        chk("drain_d", 64'(d_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbiter/sequencer sharing one single-port synchronous memory between the instruction-fetch requester and the data load/store requester.
- Sits between the core's fetch/LSU logic and a unified memory macro with 1-cycle read latency.
- Issues at most one memory command per cycle and returns read data with a valid pulse.
- Default policy: data priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, requester byte-address width.
- DATA_W, 32, data word width.
- IDX_W, 8, memory word-index width (256 words).
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_if_req  input  1  fetch read request; held with address until granted.
- i_if_addr  input  ADDR_W  fetch byte address.
- o_if_gnt  output  1  fetch accepted this cycle (combinational).
- o_if_valid  output  1  fetch read data valid (registered pulse).
- o_if_rdata  output  DATA_W  fetch read data, held between valids.
- i_d_req  input  1  data request; held until granted.
- i_d_we  input  1  1 = write, 0 = read.
- i_d_addr  input  ADDR_W  data byte address.
- i_d_wdata  input  DATA_W  write data.
- o_d_gnt  output  1  data accepted this cycle (combinational).
- o_d_valid  output  1  data read/write completion pulse (registered).
- o_d_rdata  output  DATA_W  load data, held between read completions.
- o_mem_en  output  1  memory command strobe.
- o_mem_we  output  1  memory write enable.
- o_mem_addr  output  IDX_W  word index = addr[IDX_W+1:2].
- o_mem_wdata  output  DATA_W  memory write data.
- i_mem_rdata  input  DATA_W  memory read data, valid the cycle after a read command.

Behaviour:
- Reset (asynchronous, rst_n low):
  - o_if_valid, o_d_valid, o_if_rdata, o_d_rdata, starvation counter, pending-owner register and last-grant flag all clear to 0.
  - Comb outputs (gnt, o_mem_*) are 0 while reset is asserted.
  - An in-flight read is dropped; no valid follows reset release.
- Arbitration (every cycle, combinational):
  - winner = data if i_d_req and not force_if; else fetch if i_if_req.
  - force_if = (starve_cnt == STARVE_MAX) and i_if_req.
  - Exactly one gnt is high at a time. gnt high drives o_mem_en = 1; o_mem_addr and o_mem_wdata mux the winner's fields; o_mem_we = i_d_we for data, 0 for fetch.
- Pipelining and latency:
  - A new grant is allowed every cycle, including the cycle in which a previous read completes.
  - Read granted in cycle N gives owner valid in N+1; o_*_rdata captures i_mem_rdata at the N+1 edge and holds it.
  - Data write granted in N gives o_d_valid in N+1 with o_d_rdata unchanged. The memory is written at the N edge.
  - Pending-owner register is 2 bits {if, d}, loaded from the grants each cycle.
- Starvation counter (4-bit, saturating at STARVE_MAX):
  - Increments when i_if_req & ~o_if_gnt.
  - Clears on o_if_gnt or when ~i_if_req.
- Address handling:
  - Low 2 bits are ignored.
  - Bits above IDX_W+1 are ignored, so accesses wrap modulo 2^IDX_W words.
- Requester protocol:
  - Dropping req before gnt is legal and withdraws the request.
  - Changing the address while req is high and ungranted is legal; the value sampled in the grant cycle is used.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin policy replaces data priority and the starvation counter (counter not instantiated).
  - On conflict, the requester not granted last wins.
  - A 1-bit last-grant flag updates on every grant; it resets to "data", so fetch wins the first conflict.
- Undefined: data-priority plus starvation policy as above.

Test Plan:
- Fetch only: i_if_req=1, addr 0x10 with mem[4]=0xDEADBEEF -> o_if_gnt same cycle, o_mem_addr=4, o_if_valid next cycle, o_if_rdata=0xDEADBEEF held afterwards.
- Store then load: d write 0x24 <= 0x12345678, then d read 0x24 back-to-back -> o_d_valid pulses two consecutive cycles; second returns 0x12345678; o_d_rdata unchanged after the write.
- Conflict with starvation (STARVE_MAX=4): both req held high continuously -> data granted for 4 cycles, fetch granted on 5th, counter cleared, data resumes.
- Wrap: read address 0x400 (IDX_W=8) -> o_mem_addr=0, data from mem[0].
- Reset mid-read: assert rst_n low the cycle after a read grant -> no valid pulse, rdata=0, counter=0; first grant after release behaves normally.
- With MEM_ARB_RR_EN: both req held high -> grants alternate fetch, data, fetch, data starting with fetch.
